// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler.
package mult_sched_pkg;

    localparam int unsigned OPW   = 4;
    localparam int unsigned PRODW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mult4x4_array.sv
// Combinational unsigned array multiplier: shifted partial-product rows summed.
module mult4x4_array
    import mult_sched_pkg::*;
(
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [PRODW-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < OPW; i++) begin
            p = p + (PRODW'(a & {OPW{b[i]}}) << i);
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping to index 0.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int unsigned     pos;
    logic [IDW-1:0]  pos_idx;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos     = (32'(ptr) + k) % NREQ;
            pos_idx = IDW'(pos);
            if (!any && req[pos_idx]) begin
                any            = 1'b1;
                grant[pos_idx] = 1'b1;
                idx            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one 4x4 multiplier among NREQ requesters.
// Optional feature macro: MULT_ZERO_BYPASS_EN (zero operand skips the compute cycle).
module mult_rr_sched
    import mult_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    output logic [PRODW-1:0]    res_data,
    output logic [IDW-1:0]      res_id,
    input  logic                res_ready
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_idx;
    logic             any_req;
    logic [IDW-1:0]   rr_ptr;
    logic [OPW-1:0]   win_a;
    logic [OPW-1:0]   win_b;
    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   op_b;
    logic [IDW-1:0]   op_id;
    logic [PRODW-1:0] prod;
    logic             hs;
    logic             skip;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (any_req)
    );

    mult4x4_array u_mult (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // Grant is only offered while idle and out of reset.
    assign req_ready = (rst_n && (state == ST_IDLE)) ? grant : '0;
    assign hs        = rst_n && (state == ST_IDLE) && any_req;

    // Winner operand select: one-hot grant OR-mux.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_a = win_a | req_a[i*OPW +: OPW];
                win_b = win_b | req_b[i*OPW +: OPW];
            end
        end
    end

`ifdef MULT_ZERO_BYPASS_EN
    assign skip = (win_a == '0) || (win_b == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hs) state_nxt = skip ? ST_DONE : ST_CALC;
            ST_CALC: state_nxt = ST_DONE;
            ST_DONE: if (res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, pointer advance and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
        end else begin
            res_valid <= (state_nxt == ST_DONE);
            if (hs) begin
                rr_ptr <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                op_id  <= win_idx;
                if (skip) begin
                    res_data <= '0;
                    res_id   <= win_idx;
                end else begin
                    op_a <= win_a;
                    op_b <= win_b;
                end
            end
            if (state == ST_CALC) begin
                res_data <= prod;
                res_id   <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Self-checking bench for mult_rr_sched: latency/round-robin reference model plus directed vectors.
module tb_mult_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_a;
    logic [4*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic [7:0]          res_data;
    logic [IDW-1:0]      res_id;
    logic                res_ready;

    int n_cmp = 0;
    int n_err = 0;

    mult_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[4*i +: 4] = 4'(a);
        req_b[4*i +: 4] = 4'(b);
    endtask

    // Reference model: a request is granted while idle, its product appears
    // a fixed number of edges later and is held until the consumer takes it.
    bit   model_ok = 1'b0;
    int   m_ptr = 0;
    int   m_cnt = 0;
    bit   m_valid = 1'b0;
    int   m_data = 0;
    int   m_id = 0;
    int   m_pend = 0;
    int   m_pid = 0;

    function automatic int pick(input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int w;
        if (!rst_n || m_valid || m_cnt != 0) return '0;
        w = pick(m_ptr);
        if (w < 0) return '0;
        return NREQ'(1) << w;
    endfunction

    always @(posedge clk) begin
        int w, a, b;
        if (!rst_n) begin
            model_ok = 1'b1;
            m_ptr = 0; m_cnt = 0; m_valid = 1'b0; m_data = 0; m_id = 0;
        end else if (m_valid) begin
            if (res_ready) m_valid = 1'b0;
        end else begin
            if (m_cnt == 0) begin
                w = pick(m_ptr);
                if (w >= 0) begin
                    a = int'(req_a[4*w +: 4]);
                    b = int'(req_b[4*w +: 4]);
                    m_pend = a * b;
                    m_pid  = w;
                    m_ptr  = (w + 1) % NREQ;
                    m_cnt  = (BYP && (a == 0 || b == 0)) ? 1 : 2;
                end
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_data  = m_pend;
                    m_id    = m_pid;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready()));
            check("res_valid", 32'(res_valid), 32'(m_valid));
            if (m_valid) begin
                check("res_data", 32'(res_data), 32'(m_data));
                check("res_id", 32'(res_id), 32'(m_id));
            end
        end
    end

    // Grant / result order logs for the round-robin test.
    bit log_en = 1'b0;
    int grant_log[$];
    int res_log[$];

    always @(negedge clk) begin
        if (log_en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
            end
            if (res_valid && res_ready) res_log.push_back(int'(res_id));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && (res_valid || m_cnt != 0 || m_valid); c++) step();
        repeat (2) step();
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int lat;

    initial begin
        rst_n     = 1'b0;
        res_ready = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, i + 2);

        // Reset held with every requester valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);

        // Single request from requester 2: 7*9
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'b0100;
        set_req(2, 7, 9);
        @(negedge clk);
        check("single_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_n1_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("single_n2_valid", 32'(res_valid), 32'd1);
        check("single_data", 32'(res_data), 32'd63);
        check("single_id", 32'(res_id), 32'd2);
        drain();

        // Round-robin from a fresh pointer, every requester valid
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, i + 3, 2 * i + 1);
        step();
        rst_n = 1'b1;
        req_valid = '1;
        grant_log.delete();
        res_log.delete();
        log_en = 1'b1;
        for (int c = 0; c < 60 && res_log.size() < 5; c++) begin
            step();
            if (grant_log.size() >= 5) req_valid = '0;
        end
        req_valid = '0;
        log_en = 1'b0;
        check("rr_grant_count", 32'(grant_log.size()), 32'd5);
        check("rr_result_count", 32'(res_log.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_grant_%0d", k),
                  (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));
            check($sformatf("rr_res_id_%0d", k),
                  (k < res_log.size()) ? 32'(res_log[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));
        end
        drain();

        // Backpressure on 15*15 with all requesters still asking
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 15, 15);
        req_valid = '1;
        lat = 0;
        while (!res_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("bp_result_seen", 32'(res_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_held", 32'(res_valid), 32'd1);
            check("bp_data", 32'(res_data), 32'd225);
            check("bp_no_grant", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
        drain();

        // Reset during CALC discards the operation
        set_req(1, 5, 6);
        req_valid = 4'b0010;
        @(negedge clk);
        check("mid_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_no_result", 32'(res_valid), 32'd0);
        step();
        rst_n = 1'b1;
        req_valid = '1;
        @(negedge clk);
        check("mid_grant_after_rst", 32'(req_ready), 32'b0001);
        check("mid_no_result2", 32'(res_valid), 32'd0);
        step();
        req_valid = '0;
        drain();

        // Zero operand on requester 3: 0*13
        set_req(3, 0, 13);
        req_valid = 4'b1000;
        @(negedge clk);
        check("zero_grant", 32'(req_ready), 32'b1000);
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            lat++;
            if (res_valid) break;
        end
        check("zero_latency", 32'(lat), BYP ? 32'd1 : 32'd2);
        check("zero_data", 32'(res_data), 32'd0);
        check("zero_id", 32'(res_id), 32'd3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
